pipe_ctrl: RTL

Central pipeline sequencer for the six-stage CPU (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
- Merges stall requests from the IF, ID, EX and MEM stages into the stall[5:0] vector consumed by every pipeline register.
- Recognises exceptions committed at MEM, then issues flush and the redirect PC.
- Runs a watchdog on MEM-stage bus stalls that converts a hung access into a bus-error exception.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_stall_watchdog.sv | 45 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall masks, exception
// codes, FSM state encoding and the redirect-target helper.
package pipe_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Bit 0 = PC ... bit 5 = WB. A stalled stage also freezes every
    // earlier stage, so each mask is a run of Stop bits from bit 0.
    localparam logic [5:0] STALL_MEM  = {NoStop, {5{Stop}}};
    localparam logic [5:0] STALL_EX   = {{2{NoStop}}, {4{Stop}}};
    localparam logic [5:0] STALL_ID   = {{3{NoStop}}, {3{Stop}}};
    localparam logic [5:0] STALL_IF   = {{4{NoStop}}, {2{Stop}}};
    localparam logic [5:0] STALL_NONE = {6{NoStop}};

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEMWAIT   = 2'd1,
        ST_TOFLUSH   = 2'd2,
        ST_POSTFLUSH = 2'd3
    } state_e;

    // eret returns to EPC; every other exception enters the common handler.
    function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                                input logic [31:0] epc,
                                                input logic [31:0] vec);
        return (code == EXC_ERET) ? epc : vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Watchdog for MEM-stage bus stalls: counts consecutive stalled cycles and
// flags when the count reaches TIMEOUT_CYC.
module stall_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,        // synchronous, active low
    input  logic load_i,     // start a new stall episode at 1
    input  logic inc_i,      // one more stalled cycle
    input  logic clr_i,      // episode over
    output logic timeout_o
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats increment; hold at the limit.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (which would infer a latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = W'(1);
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values regardless of block ordering.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges stage stall requests, turns MEM-stage
// exceptions into a flush plus redirect, and converts hung bus accesses into
// a bus-error flush via the stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] BUSERR_CODE = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,          // synchronous, active low
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_err,
    output logic [31:0] stall_cnt
);

    state_e      state_q, state_d;
    logic        bus_err_q;
    logic [31:0] stall_cnt_q;

    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic        exc_take;
    logic        wd_load, wd_inc, wd_clr, wd_timeout;

    stall_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .load_i    (wd_load),
        .inc_i     (wd_inc),
        .clr_i     (wd_clr),
        .timeout_o (wd_timeout)
    );

    // Same-cycle stall/flush/redirect decode and next-state selection.
    always_comb begin
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = ZeroWord;
        state_d  = state_q;
        wd_load  = 1'b0;
        wd_inc   = 1'b0;
        wd_clr   = 1'b0;

        if (stallreq_mem)      stall_c = STALL_MEM;
        else if (stallreq_ex)  stall_c = STALL_EX;
        else if (stallreq_id)  stall_c = STALL_ID;
        else if (stallreq_if)  stall_c = STALL_IF;

        // An exception is only taken once the MEM bus access has completed.
        exc_take = ((state_q == ST_RUN) || (state_q == ST_MEMWAIT)) &&
                   (excepttype != ZeroWord) && !stallreq_mem;

        unique case (state_q)
            ST_RUN: begin
                if (exc_take) begin
                    state_d = ST_POSTFLUSH;
                end else if (stallreq_mem) begin
                    state_d = ST_MEMWAIT;
                    wd_load = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (!stallreq_mem) begin
                    wd_clr  = 1'b1;
                    state_d = exc_take ? ST_POSTFLUSH : ST_RUN;
                end else if (wd_timeout) begin
                    wd_clr  = 1'b1;
                    state_d = ST_TOFLUSH;
                end else begin
                    wd_inc  = 1'b1;
                end
            end
            ST_TOFLUSH: begin
                flush_c  = 1'b1;
                new_pc_c = redirect_pc(BUSERR_CODE, cp0_epc, EXC_VECTOR);
                state_d  = ST_POSTFLUSH;
            end
            ST_POSTFLUSH: begin
                // MEM holds a bubble this cycle, so exceptions are not looked at.
                if (stallreq_mem) begin
                    state_d = ST_MEMWAIT;
                    wd_load = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (exc_take) begin
            flush_c  = 1'b1;
            new_pc_c = redirect_pc(excepttype, cp0_epc, EXC_VECTOR);
        end

        // A flush kills every stage, so nothing may be held over it.
        if (flush_c) stall_c = STALL_NONE;
    end

    // FSM state, bus-error pulse and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= ZeroWord;
        end else begin
            state_q   <= state_d;
            bus_err_q <= (state_q == ST_TOFLUSH);
            if ((stall_c != STALL_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall     = stall_c;
    assign flush     = flush_c;
    assign new_pc    = new_pc_c;
    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
